// File: rtl/inst_fetch_queue_pkg.sv
// inst_fetch_queue_pkg: shared fetch types, state encoding and constants
package inst_fetch_queue_pkg;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} fetch_state_t;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam int INST_W = 32;
  localparam logic [31:0] PC_STEP = 32'd4;
  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [31:0]       pc;
    logic [31:0]       pc4;
  } fetch_entry_t;
endpackage

// File: rtl/ifq_fifo.sv
// ifq_fifo: circular queue of fetched {inst, pc, pc4} entries with flush
// Ports: i_clk/i_reset_n (sync, active-low), i_flush clears all entries,
// i_push/i_din write, i_pop removes head, o_empty/o_count occupancy,
// o_head current head (holds the last head while empty).
module ifq_fifo import inst_fetch_queue_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  input  logic                    i_flush,
  input  logic                    i_push,
  input  fetch_entry_t            i_din,
  input  logic                    i_pop,
  output logic                    o_empty,
  output logic [$clog2(DEPTH):0]  o_count,
  output fetch_entry_t            o_head
);
  localparam int AW = $clog2(DEPTH);
  fetch_entry_t  r_mem [DEPTH];
  fetch_entry_t  r_last;
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0]   r_cnt;
  logic          w_full, w_push, w_pop;
  assign w_full  = r_cnt == (AW+1)'(DEPTH);
  assign o_empty = r_cnt == '0;
  assign w_push  = i_push && !w_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_count = r_cnt;
  // r_last tracks the visible head so it stays on the outputs once empty
  assign o_head  = o_empty ? r_last : r_mem[r_rd];
  always_ff @(posedge i_clk)
    if (w_push && !i_flush) r_mem[r_wr] <= i_din;
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_wr   <= '0;
      r_rd   <= '0;
      r_cnt  <= '0;
      r_last <= '0;
    end else begin
      r_last <= o_head;
      if (i_flush) begin
        r_wr  <= '0;
        r_rd  <= '0;
        r_cnt <= '0;
      end else begin
        r_wr  <= r_wr + AW'(w_push);
        r_rd  <= r_rd + AW'(w_pop);
        r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
      end
    end
  end
endmodule

// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: fetch PC owner, imem req/ack master and decode-side queue
// Ports: i_clk/i_reset_n (sync, active-low); i_redirect/i_redirect_pc restart
// fetch; o_imem_req/o_imem_addr/i_imem_ack/i_imem_rdata memory handshake;
// o_out_valid/i_out_ready/o_out_inst/o_out_pc/o_out_pc4 decode handshake.
module inst_fetch_queue import inst_fetch_queue_pkg::*; #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_rdata,
  output logic        o_out_valid,
  input  logic        i_out_ready,
  output logic [31:0] o_out_inst,
  output logic [31:0] o_out_pc,
  output logic [31:0] o_out_pc4
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  fetch_state_t  r_state;
  logic [31:0]   r_pc;
  logic          r_req;
  logic [31:0]   w_target, w_pc4;
  logic          w_push, w_pop, w_empty;
  logic [CW-1:0] w_count;
  fetch_entry_t  w_entry, w_head;
  assign w_target    = i_redirect_pc & ~32'd3;
  assign w_pc4       = r_pc + PC_STEP;
  assign w_push      = r_state == S_WAIT && i_imem_ack && !i_redirect;
  assign w_entry     = '{inst: i_imem_rdata, pc: r_pc, pc4: w_pc4};
  assign o_out_valid = !w_empty;
  assign w_pop       = o_out_valid && i_out_ready;
  assign o_imem_req  = r_req;
  assign o_imem_addr = r_pc;
  assign o_out_inst  = w_head.inst;
  assign o_out_pc    = w_head.pc;
  assign o_out_pc4   = w_head.pc4;
  // Issue only with a free slot: with one request in flight, a push never overflows
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state <= S_IDLE;
      r_req   <= 1'b0;
      r_pc    <= RESET_PC;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_redirect) r_pc <= w_target;
          else if (w_count < FULL) begin
            r_state <= S_WAIT;
            r_req   <= 1'b1;
          end
        end
        S_WAIT: begin
          if (i_redirect) begin
            r_pc    <= w_target;
            r_state <= i_imem_ack ? S_IDLE : S_DROP;
            r_req   <= !i_imem_ack;
          end else if (i_imem_ack) begin
            r_pc    <= w_pc4;
            r_state <= S_IDLE;
            r_req   <= 1'b0;
          end
        end
        S_DROP: begin
          if (i_redirect) r_pc <= w_target;
          if (i_imem_ack) begin
            r_state <= S_IDLE;
            r_req   <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end
  ifq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_flush   (i_redirect),
    .i_push    (w_push),
    .i_din     (w_entry),
    .i_pop     (w_pop),
    .o_empty   (w_empty),
    .o_count   (w_count),
    .o_head    (w_head)
  );
endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb_inst_fetch_queue: directed bench for inst_fetch_queue with a latency-programmable memory
module tb_inst_fetch_queue;
  import inst_fetch_queue_pkg::*;
  logic clk = 0, rst_n = 0, redirect = 0, ready = 0, ack = 0, req, valid, req_d = 0;
  logic [31:0] redirect_pc = 0, rdata = 0, addr, inst, pc, pc4;
  int lat = 1, mcnt = 0, n_chk = 0, n_pass = 0;
  logic [31:0] iss_q [$];
  fetch_entry_t pop_q [$];
  inst_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_redirect(redirect), .i_redirect_pc(redirect_pc),
    .o_imem_req(req), .o_imem_addr(addr), .i_imem_ack(ack), .i_imem_rdata(rdata),
    .o_out_valid(valid), .i_out_ready(ready), .o_out_inst(inst), .o_out_pc(pc), .o_out_pc4(pc4)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (!rst_n) mcnt <= 0;
    else if (req && ack) mcnt <= 0;
    else if (req) mcnt <= mcnt + 1;
  end
  always @(negedge clk) begin
    ack = req && (mcnt >= lat);
    rdata = 32'h1000 + addr;
  end
  always @(posedge clk) begin
    if (rst_n) begin
      if (req && !req_d) iss_q.push_back(addr);
      if (valid && ready && !redirect) pop_q.push_back('{inst: inst, pc: pc, pc4: pc4});
    end
    req_d <= req;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic reset_dut(input int l, input logic rdy);
    rst_n = 0; redirect = 0; ready = rdy; lat = l;
    step(2);
    iss_q.delete(); pop_q.delete();
    rst_n = 1;
  endtask
  task automatic wait_iss(input int n);
    for (int i = 0; i < 200 && iss_q.size() < n; i++) step();
    check("iss_timeout", 32'(iss_q.size() >= n), 1);
  endtask
  task automatic wait_pops(input int n);
    for (int i = 0; i < 200 && pop_q.size() < n; i++) step();
    check("pop_timeout", 32'(pop_q.size() >= n), 1);
  endtask
  task automatic check_pop(input string tag, input int i, input logic [31:0] ei, input logic [31:0] ep, input logic [31:0] ep4);
    check({tag, "_inst"}, pop_q[i].inst, ei);
    check({tag, "_pc"}, pop_q[i].pc, ep);
    check({tag, "_pc4"}, pop_q[i].pc4, ep4);
  endtask
  initial begin
    step(2);
    check("rst_req", 32'(req), 0);
    check("rst_addr", addr, 32'h0);
    check("rst_valid", 32'(valid), 0);
    check("rst_inst", inst, 0);
    check("rst_pc", pc, 0);
    check("rst_pc4", pc4, 0);
    // reset and stream
    reset_dut(1, 1);
    step();
    check("first_req", 32'(req), 1);
    check("first_addr", addr, 32'h0);
    wait_pops(3);
    check("str_iss0", iss_q[0], 32'h0);
    check("str_iss1", iss_q[1], 32'h4);
    check("str_iss2", iss_q[2], 32'h8);
    check_pop("str0", 0, 32'h1000, 32'h0, 32'h4);
    check_pop("str1", 1, 32'h1004, 32'h4, 32'h8);
    check_pop("str2", 2, 32'h1008, 32'h8, 32'hC);
    // backpressure with zero-latency memory
    reset_dut(0, 0);
    step(20);
    check("bp_niss", iss_q.size(), 4);
    check("bp_iss3", iss_q[3], 32'hC);
    check("bp_req", 32'(req), 0);
    check("bp_valid", 32'(valid), 1);
    check("bp_pc", pc, 32'h0);
    ready = 1; step(); ready = 0;
    step(3);
    check("bp_npop", pop_q.size(), 1);
    check_pop("bp_pop", 0, 32'h1000, 32'h0, 32'h4);
    check("bp_niss2", iss_q.size(), 5);
    check("bp_iss4", iss_q[4], 32'h10);
    check("bp_full_req", 32'(req), 0);
    // redirect while waiting, response arrives later and is dropped
    reset_dut(3, 0);
    wait_iss(3);
    check("rw_addr8", addr, 32'h8);
    redirect = 1; redirect_pc = 32'h203;
    step(); redirect = 0;
    check("rw_valid", 32'(valid), 0);
    check("rw_req_held", 32'(req), 1);
    check("rw_addr", addr, 32'h200);
    step(2);
    check("rw_drop_req", 32'(req), 0);
    check("rw_drop_valid", 32'(valid), 0);
    ready = 1;
    wait_pops(1);
    check("rw_iss3", iss_q[3], 32'h200);
    check_pop("rw_pop", 0, 32'h1200, 32'h200, 32'h204);
    // same-cycle redirect and ack while a pop is offered
    reset_dut(1, 0);
    wait_iss(2);
    check("sc_valid", 32'(valid), 1);
    redirect = 1; redirect_pc = 32'h300; ready = 1;
    step(); redirect = 0;
    check("sc_flush", 32'(valid), 0);
    check("sc_req", 32'(req), 0);
    check("sc_addr", addr, 32'h300);
    wait_pops(1);
    check("sc_iss2", iss_q[2], 32'h300);
    check_pop("sc_pop", 0, 32'h1300, 32'h300, 32'h304);
    // PC wrap-around
    reset_dut(1, 1);
    redirect = 1; redirect_pc = 32'hFFFF_FFF8;
    step(); redirect = 0;
    wait_pops(3);
    check("wr_iss0", iss_q[0], 32'hFFFF_FFF8);
    check_pop("wr0", 0, 32'h0000_0FF8, 32'hFFFF_FFF8, 32'hFFFF_FFFC);
    check_pop("wr1", 1, 32'h0000_0FFC, 32'hFFFF_FFFC, 32'h0);
    check_pop("wr2", 2, 32'h0000_1000, 32'h0, 32'h4);
    // reset mid-operation
    reset_dut(3, 0);
    wait_iss(3);
    check("mr_pre_valid", 32'(valid), 1);
    check("mr_pre_req", 32'(req), 1);
    rst_n = 0;
    step();
    check("mr_req", 32'(req), 0);
    check("mr_valid", 32'(valid), 0);
    check("mr_inst", inst, 0);
    check("mr_pc", pc, 0);
    check("mr_pc4", pc4, 0);
    check("mr_addr", addr, 32'h0);
    iss_q.delete(); pop_q.delete();
    rst_n = 1;
    step();
    check("mr_req_rel", 32'(req), 1);
    check("mr_addr_rel", addr, 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
